// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU sequencer: op codes,
// FSM state encoding and multiply iteration count.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_CMP = 2'b10,
    OP_MUL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_MUL  = 2'b10,
    S_RESP = 2'b11
  } state_e;

  localparam int MUL_ITER = 8;
  localparam int ITER_W   = 3;

endpackage

// File: rtl/alu_sequencer_alu.sv
// Shared adder/subtractor; bit W of sum is carry
// for add and borrow for subtract.
module alu_sequencer_alu #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W:0]   sum
);

  always_comb begin
    if (sub) sum = {1'b0, a} - {1'b0, b};
    else     sum = {1'b0, a} + {1'b0, b};
  end

endmodule

// File: rtl/alu_sequencer.sv
// Request/response ALU sequencer: ADD/SUB/CMP in one
// cycle, MUL as 8 shift-add passes through one adder.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_carry,
  output logic              rsp_zero,
  output logic              flags_carry,
  output logic              flags_zero,
  output logic              busy
);

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]   mplr_q, mplr_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic                carry_q, carry_d;
  logic                zero_q, zero_d;
  logic                fc_q, fc_d;
  logic                fz_q, fz_d;

  logic [DATA_W-1:0]   alu_a, alu_b;
  logic                alu_sub;
  logic [DATA_W:0]     alu_sum;

  alu_sequencer_alu #(.W(DATA_W)) u_alu (
    .a   (alu_a),
    .b   (alu_b),
    .sub (alu_sub),
    .sum (alu_sum)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    mplr_d  = mplr_q;
    iter_d  = iter_q;
    res_d   = res_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    fc_d    = fc_q;
    fz_d    = fz_q;
    alu_a   = acc_q;
    alu_b   = mplr_q[0] ? a_q : '0;
    alu_sub = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d    = op_e'(req_op);
          a_d     = req_a;
          b_d     = req_b;
          acc_d   = '0;
          mplr_d  = req_b;
          iter_d  = '0;
          state_d = (op_e'(req_op) == OP_MUL) ? S_MUL : S_EXEC;
        end
      end
      S_EXEC: begin
        alu_a   = a_q;
        alu_b   = b_q;
        alu_sub = (op_q != OP_ADD);
        res_d   = (op_q == OP_CMP) ? a_q : alu_sum[DATA_W-1:0];
        carry_d = alu_sum[DATA_W];
        zero_d  = (alu_sum == '0);
        fc_d    = carry_d;
        fz_d    = zero_d;
        state_d = S_RESP;
      end
      S_MUL: begin
        // {acc, mplr} shifts right with the adder carry on top
        acc_d  = alu_sum[DATA_W:1];
        mplr_d = {alu_sum[0], mplr_q[DATA_W-1:1]};
        iter_d = iter_q + 1'b1;
        if (iter_q == ITER_W'(MUL_ITER - 1)) begin
          res_d   = mplr_d;
          carry_d = |acc_d;
          zero_d  = (mplr_d == '0);
          fc_d    = carry_d;
          fz_d    = zero_d;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      mplr_q  <= '0;
      iter_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      fc_q    <= 1'b0;
      fz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      mplr_q  <= mplr_d;
      iter_q  <= iter_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      fc_q    <= fc_d;
      fz_q    <= fz_d;
    end
  end

  assign req_ready   = rst_n && (state_q == S_IDLE);
  assign rsp_valid   = (state_q == S_RESP);
  assign busy        = (state_q != S_IDLE);
  assign rsp_result  = res_q;
  assign rsp_carry   = carry_q;
  assign rsp_zero    = zero_q;
  assign flags_carry = fc_q;
  assign flags_zero  = fz_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed table,
// randomized ops against an arithmetic model, corner sequences.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [7:0] req_a, req_b;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_result;
  logic       rsp_carry, rsp_zero;
  logic       flags_carry, flags_zero;
  logic       busy;

  int n_chk  = 0;
  int n_fail = 0;

  alu_sequencer #(.DATA_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_carry   (rsp_carry),
    .rsp_zero    (rsp_zero),
    .flags_carry (flags_carry),
    .flags_zero  (flags_zero),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       c;
    logic       z;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference: plain arithmetic on the operation's definition
  task automatic model(input logic [1:0] op, input logic [7:0] a,
                       input logic [7:0] b, output logic [7:0] r,
                       output logic c, output logic z);
    int ia, ib, s;
    ia = a;
    ib = b;
    case (op)
      2'd0: begin
        s = ia + ib;
        r = 8'(s % 256); c = (s > 255); z = (s == 0);
      end
      2'd1: begin
        s = ia - ib;
        r = 8'((s + 256) % 256); c = (ia < ib); z = (ia == ib);
      end
      2'd2: begin
        r = a; c = (ia < ib); z = (ia == ib);
      end
      default: begin
        s = ia * ib;
        r = 8'(s % 256); c = (s > 255); z = (r == 8'd0);
      end
    endcase
  endtask

  // Caller is at a negedge; returns at a negedge in IDLE.
  task automatic do_op(input logic [1:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] er,
                       input logic ec, input logic ez,
                       input int stall);
    int cyc, lat;
    bit seen;
    lat = (op == 2'd3) ? 9 : 2;
    cyc = 0;
    while (!req_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("req_ready_before", req_ready, 1);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    rsp_ready = (stall == 0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_a     = 8'($urandom);
    req_b     = 8'($urandom);
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid) seen = 1;
    end
    chk("latency", cyc, lat);
    chk("rsp_result", rsp_result, er);
    chk("rsp_carry", rsp_carry, ec);
    chk("rsp_zero", rsp_zero, ez);
    chk("flags_carry", flags_carry, ec);
    chk("flags_zero", flags_zero, ez);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_valid", rsp_valid, 1);
      chk("stall_result", {rsp_result, rsp_carry, rsp_zero},
          {er, ec, ez});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("rsp_valid_drop", rsp_valid, 0);
    chk("req_ready_after", req_ready, 1);
  endtask

  vec_t vecs[12];

  initial begin
    logic [7:0] er;
    logic ec, ez, seen_rsp;
    logic [1:0] rop;
    logic [7:0] ra, rb;
    int cyc;

    vecs[0]  = '{2'd0, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0};
    vecs[1]  = '{2'd0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b0};
    vecs[2]  = '{2'd0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1};
    vecs[3]  = '{2'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    vecs[4]  = '{2'd1, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
    vecs[5]  = '{2'd1, 8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
    vecs[6]  = '{2'd2, 8'h42, 8'h42, 8'h42, 1'b0, 1'b1};
    vecs[7]  = '{2'd2, 8'h10, 8'h20, 8'h10, 1'b1, 1'b0};
    vecs[8]  = '{2'd3, 8'h0C, 8'h0B, 8'h84, 1'b0, 1'b0};
    vecs[9]  = '{2'd3, 8'h10, 8'h10, 8'h00, 1'b1, 1'b1};
    vecs[10] = '{2'd3, 8'hFF, 8'hFF, 8'h01, 1'b1, 1'b0};
    vecs[11] = '{2'd3, 8'h00, 8'h37, 8'h00, 1'b0, 1'b1};

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = 2'd0;
    req_a     = 8'h00;
    req_b     = 8'h00;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_outputs",
        {busy, rsp_valid, req_ready, rsp_result, rsp_carry,
         rsp_zero, flags_carry, flags_zero}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", req_ready, 1);

    foreach (vecs[i])
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res,
            vecs[i].c, vecs[i].z, 0);

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom);
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      model(rop, ra, rb, er, ec, ez);
      do_op(rop, ra, rb, er, ec, ez, (i % 5 == 0) ? 2 : 0);
    end

    // Stalled response with an interfering request
    req_valid = 1'b1;
    req_op    = 2'd0;
    req_a     = 8'h05;
    req_b     = 8'h03;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    req_op = 2'd3;
    req_a  = 8'hFF;
    req_b  = 8'hFF;
    repeat (2) @(negedge clk);
    chk("stall_rsp_valid", rsp_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_hold", {rsp_valid, req_ready, busy, rsp_result,
                         rsp_carry, rsp_zero}, {3'b101, 8'h08, 2'b00});
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("ignored_req_idle", {busy, req_ready, rsp_valid}, 3'b010);
    chk("ignored_req_flags", {flags_carry, flags_zero}, 2'b00);

    do_op(2'd2, 8'h42, 8'h42, 8'h42, 1'b0, 1'b1, 0);

    // Reset during MUL iteration 4
    req_valid = 1'b1;
    req_op    = 2'd3;
    req_a     = 8'h0C;
    req_b     = 8'h0B;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mul_busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_reset_outputs",
        {busy, rsp_valid, req_ready, rsp_result, rsp_carry,
         rsp_zero, flags_carry, flags_zero}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_mid_reset", req_ready, 1);
    seen_rsp = 1'b0;
    for (cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (rsp_valid || busy) seen_rsp = 1'b1;
    end
    chk("no_rsp_after_reset", seen_rsp, 0);

    do_op(2'd0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, operand/result width; only 8 is supported.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  request present.
REQ-005 SHALL have port req_ready  output  1  request accepted when high with req_valid.
REQ-006 SHALL have port req_op  input  2  00 ADD, 01 SUB, 10 CMP, 11 MUL.
REQ-007 SHALL have ports req_a, req_b  input  8  operands.
REQ-008 SHALL have port rsp_valid  output  1  response present.
REQ-009 SHALL have port rsp_ready  input  1  response consumed when high with rsp_valid.
REQ-010 SHALL have port rsp_result  output  8  result.
REQ-011 SHALL have ports rsp_carry, rsp_zero  output  1  flags of this response.
REQ-012 SHALL have ports flags_carry, flags_zero  output  1  persistent flag register.
REQ-013 SHALL have port busy  output  1  high in any state but IDLE.

Function
REQ-014 SHALL implement states IDLE, EXEC, MUL, RESP; req_ready high only in IDLE.
REQ-015 Acceptance (cycle N, req_valid&&req_ready) SHALL latch req_op/req_a/req_b; IDLE->EXEC for ADD/SUB/CMP, IDLE->MUL for MUL.
REQ-016 EXEC SHALL last one cycle, register result and flags, go to RESP; rsp_valid high from cycle N+2.
REQ-017 ADD: result = (A+B)[7:0], carry = bit 8 of 9-bit sum, zero = all 9 sum bits zero.
REQ-018 SUB: result = (A-B)[7:0], carry = 1 iff A<B (borrow), zero = 1 iff A==B.
REQ-019 CMP: flags as SUB; rsp_result = A unchanged.
REQ-020 MUL SHALL run exactly 8 shift-add iterations (cycles N+1..N+8) through the shared adder; rsp_valid high from N+9.
REQ-021 MUL: result = (A*B)[7:0], carry = 1 iff full product > 255, zero = 1 iff result == 0.
REQ-022 ADD 0x80+0x80 SHALL give result 0x00, carry 1, zero 0 (9-bit zero rule).
REQ-023 In RESP, rsp_result/rsp_carry/rsp_zero SHALL hold stable until rsp_valid&&rsp_ready; then RESP->IDLE, rsp_valid low next cycle.
REQ-024 flags_carry/flags_zero SHALL load from the response flags on the edge entering RESP, for every op, and hold otherwise.
REQ-025 req_valid while not IDLE SHALL be ignored (no acceptance, no side effects).
REQ-026 Minimum spacing between acceptances SHALL be 3 cycles (ADD/SUB/CMP, rsp_ready held high).

Reset
REQ-027 rst_n low at a rising edge SHALL force IDLE, rsp_valid 0, rsp_result 0x00, rsp_carry 0, rsp_zero 0, flags_carry 0, flags_zero 0, busy 0.
REQ-028 Reset mid-operation (EXEC, MUL, RESP) SHALL discard the operation; no response is ever produced for it.
REQ-029 req_ready SHALL be 0 while rst_n is low and 1 in the first cycle after release.

Structure
REQ-030 Package alu_seq_pkg SHALL hold op codes, state encoding and MUL_ITER = 8.
REQ-031 The single 8-bit adder/subtractor SHALL be one instance of the existing alu sub-module; no second adder.

Verification
REQ-032 ADD 0x05+0x03 -> rsp at N+2: result 0x08, carry 0, zero 0; flags same.
REQ-033 SUB 0x03-0x05 -> result 0xFE, carry 1, zero 0; CMP 0x42,0x42 -> result 0x42, carry 0, zero 1.
REQ-034 MUL 0x0C*0x0B -> rsp at N+9: result 0x84, carry 0; MUL 0x10*0x10 -> result 0x00, carry 1, zero 1.
REQ-035 Response with rsp_ready low 5 cycles -> outputs stable, req_ready 0, second req_valid ignored, accepted only after IDLE.
REQ-036 rst_n low in MUL iteration 4 -> next cycle IDLE, all outputs zero, no rsp_valid afterwards.
